// File: rtl/pingpong_buffer_mc.sv
// ---------------------------------------------------------------------------
// pingpong_buffer_mc
//
// Frame buffer built as a ring of NUM_BANKS banks of DEPTH samples each. A
// writer fills one bank at a time. Each full bank is committed to the reader,
// which streams the frames back out in the order they were written.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The sender holds its data stable while
// valid && !ready. The sender does not wait for ready before raising valid.
//
// Ports
//   clk_i            single clock, all logic rising-edge
//   rst_i            asynchronous active-high reset
//   write_data_i     signed sample from the writer
//   write_valid_i    writer has a sample
//   write_ready_o    buffer takes the sample (tied high in DROP_MODE=1)
//   read_data_o      signed sample to the reader, always from a register
//   read_valid_o     read_data_o holds a sample
//   read_ready_i     reader takes the sample
//   read_last_o      read_data_o is the final sample of its frame
//   frame_ready_o    one-cycle pulse per committed frame
//   overflow_o       one-cycle pulse per discarded sample
//   frames_pending_o committed banks not yet released by the reader
//   write_count_o    samples already in the current write bank
//   drop_count_o     discarded-sample count, saturates at 0xFFFF
//   rd_state_o       reader FSM state (0 idle, 1 fetch, 2 stream) for debug
// ---------------------------------------------------------------------------
module pingpong_buffer_mc #(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 256,
  parameter int NUM_BANKS = 2,
  parameter int DROP_MODE = 0,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BANK_WIDTH = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [WIDTH-1:0] write_data_i,
  input  logic                    write_valid_i,
  output logic                    write_ready_o,
  output logic signed [WIDTH-1:0] read_data_o,
  output logic                    read_valid_o,
  input  logic                    read_ready_i,
  output logic                    read_last_o,
  output logic                    frame_ready_o,
  output logic                    overflow_o,
  output logic [BANK_WIDTH:0]     frames_pending_o,
  output logic [ADDR_WIDTH:0]     write_count_o,
  output logic [15:0]             drop_count_o,
  output logic [1:0]              rd_state_o
);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_FETCH  = 2'd1,
    R_STREAM = 2'd2
  } rd_state_t;

  localparam int MEM_WORDS = NUM_BANKS * DEPTH;
  localparam logic [BANK_WIDTH-1:0] LAST_BANK  = BANK_WIDTH'(NUM_BANKS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BANK_WIDTH:0]   FULL_COUNT = (BANK_WIDTH + 1)'(NUM_BANKS);

  function automatic logic [BANK_WIDTH-1:0] next_bank(input logic [BANK_WIDTH-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_WIDTH'(1);
  endfunction

  // Sample storage, addressed {bank, addr}; contents survive reset.
  logic signed [WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [BANK_WIDTH-1:0] wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BANK_WIDTH:0]   pending;
  logic                  full;
  logic                  wr_accept;
  logic                  wr_store;
  logic                  wr_drop;
  logic                  commit;

  assign full          = (pending == FULL_COUNT);
  assign write_ready_o = (DROP_MODE != 0) ? 1'b1 : !full;
  assign wr_accept     = write_valid_i && write_ready_o;
  // While full, wr_bank is the bank the reader still owns, so nothing is stored.
  assign wr_store      = wr_accept && !full;
  assign wr_drop       = wr_accept && full;
  assign commit        = wr_store && (wr_addr == LAST_ADDR);
  assign write_count_o = {1'b0, wr_addr};

  always_ff @(posedge clk_i) begin
    if (wr_store) begin
      mem[{wr_bank, wr_addr}] <= write_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank       <= '0;
      wr_addr       <= '0;
      frame_ready_o <= 1'b0;
      overflow_o    <= 1'b0;
      drop_count_o  <= '0;
    end else begin
      frame_ready_o <= commit;
      overflow_o    <= wr_drop;
      if (wr_drop && (drop_count_o != 16'hFFFF)) begin
        drop_count_o <= drop_count_o + 16'd1;
      end
      if (wr_store) begin
        if (commit) begin
          wr_addr <= '0;
          wr_bank <= next_bank(wr_bank);
        end else begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  //
  // Pipeline: issue (address) -> mem_rdata (sync read register) -> two-entry
  // output queue (read_data_o head, skid_data behind it). A read is issued only
  // when the word it returns is guaranteed a queue slot. This keeps one
  // sample per cycle with read_ready_i held high and never overruns the queue
  // when the reader stalls.
  // ---------------------------------------------------------------------------
  rd_state_t               state;
  rd_state_t               state_next;
  logic [BANK_WIDTH-1:0]   rd_bank;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    issued_last;
  logic                    issue;
  logic [BANK_WIDTH-1:0]   issue_bank;
  logic [ADDR_WIDTH-1:0]   issue_addr;
  logic signed [WIDTH-1:0] mem_rdata;
  logic                    pipe_valid;
  logic                    pipe_last;
  logic signed [WIDTH-1:0] skid_data;
  logic                    skid_valid;
  logic                    skid_last;
  logic                    pop;
  logic                    release_bank;
  logic [1:0]              occ;
  logic                    rd_space;
  logic [BANK_WIDTH:0]     pending_next;
  logic                    head_valid;
  logic                    head_last;
  logic signed [WIDTH-1:0] head_data;
  logic                    tail_valid;
  logic                    tail_last;
  logic signed [WIDTH-1:0] tail_data;

  assign pop          = read_valid_o && read_ready_i;
  assign release_bank = pop && read_last_o;
  // Words in flight or queued; the count after this edge must stay <= 2.
  assign occ          = {1'b0, read_valid_o} + {1'b0, skid_valid} + {1'b0, pipe_valid};
  assign rd_space     = (occ - {1'b0, pop}) < 2'd2;

  // A commit and a release on the same edge cancel out.
  always_comb begin
    pending_next = pending;
    if (commit && !release_bank) begin
      pending_next = pending + (BANK_WIDTH + 1)'(1);
    end else if (!commit && release_bank) begin
      pending_next = pending - (BANK_WIDTH + 1)'(1);
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_bank = rd_bank;
    issue_addr = rd_addr;
    case (state)
      R_IDLE: begin
        if (pending != '0) begin
          issue      = 1'b1;
          issue_addr = '0;
          state_next = R_FETCH;
        end
      end
      R_FETCH: begin
        state_next = R_STREAM;
        if (rd_space && !issued_last) begin
          issue = 1'b1;
        end
      end
      R_STREAM: begin
        if (release_bank) begin
          // Prefetch word 0 of the following bank on the release edge so the
          // next frame appears after one fetch cycle.
          if (pending_next != '0) begin
            issue      = 1'b1;
            issue_bank = next_bank(rd_bank);
            issue_addr = '0;
            state_next = R_FETCH;
          end else begin
            state_next = R_IDLE;
          end
        end else if (rd_space && !issued_last) begin
          issue = 1'b1;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  // Output queue update: pop the head, then append the returning memory word.
  always_comb begin
    if (pop) begin
      head_valid = skid_valid;
      head_data  = skid_data;
      head_last  = skid_last;
      tail_valid = 1'b0;
    end else begin
      head_valid = read_valid_o;
      head_data  = read_data_o;
      head_last  = read_last_o;
      tail_valid = skid_valid;
    end
    tail_data = skid_data;
    tail_last = skid_last;
    if (pipe_valid) begin
      if (!head_valid) begin
        head_valid = 1'b1;
        head_data  = mem_rdata;
        head_last  = pipe_last;
      end else begin
        tail_valid = 1'b1;
        tail_data  = mem_rdata;
        tail_last  = pipe_last;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) begin
      mem_rdata <= mem[{issue_bank, issue_addr}];
    end
    read_data_o <= head_data;
    skid_data   <= tail_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= R_IDLE;
      rd_bank      <= '0;
      rd_addr      <= '0;
      issued_last  <= 1'b0;
      pending      <= '0;
      pipe_valid   <= 1'b0;
      pipe_last    <= 1'b0;
      read_valid_o <= 1'b0;
      read_last_o  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_last    <= 1'b0;
    end else begin
      state        <= state_next;
      pending      <= pending_next;
      pipe_valid   <= issue;
      pipe_last    <= issue && (issue_addr == LAST_ADDR);
      read_valid_o <= head_valid;
      read_last_o  <= head_last;
      skid_valid   <= tail_valid;
      skid_last    <= tail_last;
      if (issue) begin
        rd_addr     <= issue_addr + ADDR_WIDTH'(1);
        issued_last <= (issue_addr == LAST_ADDR);
      end
      if (release_bank) begin
        rd_bank <= next_bank(rd_bank);
      end
    end
  end

  assign frames_pending_o = pending;
  assign rd_state_o       = state;

endmodule

// File: tb/tb_pingpong_buffer_mc.sv
// ---------------------------------------------------------------------------
// tb_pingpong_buffer_mc
//
// Directed bench for pingpong_buffer_mc with WIDTH=16, DEPTH=8, NUM_BANKS=3.
// dut0 runs DROP_MODE=0 and dut1 runs DROP_MODE=1. The two share the clock and
// reset. 'sel' routes the driven handshakes and the observed outputs to one of
// them. Expected read data comes from exp_q, which is filled as samples are
// written.
// ---------------------------------------------------------------------------
module tb_pingpong_buffer_mc;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int NB = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // driven stimulus
  logic                sel = 1'b0;
  logic                wv  = 1'b0;
  logic signed [W-1:0] wd  = '0;
  logic                rr  = 1'b0;

  // dut0 outputs
  logic                wr0, rv0, rl0, fr0, ov0;
  logic signed [W-1:0] rd0;
  logic [2:0]          fp0;
  logic [3:0]          wc0;
  logic [15:0]         dc0;
  logic [1:0]          st0;
  // dut1 outputs
  logic                wr1, rv1, rl1, fr1, ov1;
  logic signed [W-1:0] rd1;
  logic [2:0]          fp1;
  logic [3:0]          wc1;
  logic [15:0]         dc1;
  logic [1:0]          st1;

  pingpong_buffer_mc #(.WIDTH(W), .DEPTH(D), .NUM_BANKS(NB), .DROP_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .write_data_i(wd), .write_valid_i(wv && !sel), .write_ready_o(wr0),
    .read_data_o(rd0), .read_valid_o(rv0), .read_ready_i(rr && !sel),
    .read_last_o(rl0), .frame_ready_o(fr0), .overflow_o(ov0),
    .frames_pending_o(fp0), .write_count_o(wc0), .drop_count_o(dc0),
    .rd_state_o(st0)
  );

  pingpong_buffer_mc #(.WIDTH(W), .DEPTH(D), .NUM_BANKS(NB), .DROP_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .write_data_i(wd), .write_valid_i(wv && sel), .write_ready_o(wr1),
    .read_data_o(rd1), .read_valid_o(rv1), .read_ready_i(rr && sel),
    .read_last_o(rl1), .frame_ready_o(fr1), .overflow_o(ov1),
    .frames_pending_o(fp1), .write_count_o(wc1), .drop_count_o(dc1),
    .rd_state_o(st1)
  );

  // observed outputs of the selected instance
  logic                m_ready, m_valid, m_last, m_fr, m_ov;
  logic signed [W-1:0] m_data;
  logic [2:0]          m_fp;
  logic [3:0]          m_wc;
  logic [15:0]         m_dc;
  logic [1:0]          m_st;
  assign m_ready = sel ? wr1 : wr0;
  assign m_valid = sel ? rv1 : rv0;
  assign m_last  = sel ? rl1 : rl0;
  assign m_fr    = sel ? fr1 : fr0;
  assign m_ov    = sel ? ov1 : ov0;
  assign m_data  = sel ? rd1 : rd0;
  assign m_fp    = sel ? fp1 : fp0;
  assign m_wc    = sel ? wc1 : wc0;
  assign m_dc    = sel ? dc1 : dc0;
  assign m_st    = sel ? st1 : st0;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           rd_pos  = 0;
  int           n_check = 0;
  int           n_fail  = 0;

  task automatic chk_b(input string tag, input logic got, input logic exp);
    n_check++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wv  = 1'b0;
    rr  = 1'b0;
    wd  = '0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    rd_pos = 0;
    step();
  endtask

  // One write cycle; 'keep' says whether the buffer is expected to store it.
  task automatic wr(input logic [W-1:0] d, input bit keep);
    wv = 1'b1;
    wd = d;
    step();
    wv = 1'b0;
    if (keep) exp_q.push_back(d);
  endtask

  // Check the head sample against the scoreboard; the caller ensures that
  // read_ready is high so this sample is taken on the next edge.
  task automatic expect_pop(input string tag);
    logic [W-1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk_b({tag, "_valid"}, m_valid, 1'b1);
    chk_v({tag, "_data"}, 32'(m_data), 32'(e));
    chk_b({tag, "_last"}, m_last, (rd_pos % D) == (D - 1));
    rd_pos++;
  endtask

  task automatic drain(input int n);
    rr = 1'b1;
    for (int k = 0; k < n; k++) begin
      int budget;
      budget = 0;
      while (!m_valid && budget < 10) begin
        step();
        budget++;
      end
      expect_pop("drain");
      step();
    end
    rr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_check);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ov;
    int n_fr;
    int got;
    bit stall_prev;
    logic [W-1:0] prev;

    // ---------------- single frame, DROP_MODE=0 ----------------
    sel = 1'b0;
    do_reset();
    rr = 1'b1;
    chk_b("rst_valid", m_valid, 1'b0);
    chk_b("rst_ready", m_ready, 1'b1);
    chk_v("rst_pending", 32'(m_fp), 32'd0);
    chk_v("rst_wcount", 32'(m_wc), 32'd0);
    chk_b("rst_last", m_last, 1'b0);
    chk_b("rst_frame_ready", m_fr, 1'b0);
    for (int i = 0; i < D; i++) begin
      wr(16'(i), 1'b1);
      if (i == 4) chk_v("single_wcount5", 32'(m_wc), 32'd5);
    end
    chk_b("single_frame_ready", m_fr, 1'b1);
    chk_v("single_pending1", 32'(m_fp), 32'd1);
    chk_v("single_wcount_clr", 32'(m_wc), 32'd0);
    chk_b("single_valid_t0", m_valid, 1'b0);
    step();
    chk_b("single_valid_t1", m_valid, 1'b0);
    chk_b("single_fr_pulse", m_fr, 1'b0);
    chk_v("single_state_fetch", 32'(m_st), 32'd1);
    step();
    for (int k = 0; k < D; k++) begin
      expect_pop("single");
      step();
    end
    chk_b("single_valid_end", m_valid, 1'b0);
    chk_v("single_pending0", 32'(m_fp), 32'd0);
    chk_v("single_state_idle", 32'(m_st), 32'd0);

    // ---------------- backpressure, DROP_MODE=0 ----------------
    do_reset();
    for (int i = 0; i < NB * D; i++) wr(16'(100 + i), 1'b1);
    chk_v("bp_pending3", 32'(m_fp), 32'd3);
    chk_b("bp_ready_low", m_ready, 1'b0);
    chk_b("bp_valid_head", m_valid, 1'b1);
    chk_v("bp_head_data", 32'(m_data), 32'd100);
    wv = 1'b1;
    wd = 16'd999;
    step();
    wv = 1'b0;
    chk_v("bp_blocked_wcount", 32'(m_wc), 32'd0);
    chk_v("bp_blocked_pending", 32'(m_fp), 32'd3);
    rr = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (k == D - 1) chk_b("bp_ready_before_release", m_ready, 1'b0);
      expect_pop("bp");
      step();
    end
    chk_b("bp_ready_after_release", m_ready, 1'b1);
    chk_v("bp_pending2", 32'(m_fp), 32'd2);
    chk_b("bp_refetch_gap", m_valid, 1'b0);
    drain(2 * D);
    chk_v("bp_pending_end", 32'(m_fp), 32'd0);

    // ---------------- drop mode, DROP_MODE=1 ----------------
    sel = 1'b1;
    do_reset();
    n_ov = 0;
    n_fr = 0;
    for (int i = 0; i < NB * D + 4; i++) begin
      wr(16'(200 + i), i < NB * D);
      if (m_ov) n_ov++;
      if (m_fr) n_fr++;
    end
    step();
    chk_b("drop_ov_clear", m_ov, 1'b0);
    chk_v("drop_ov_pulses", 32'(n_ov), 32'd4);
    chk_v("drop_fr_pulses", 32'(n_fr), 32'd3);
    chk_v("drop_count", 32'(m_dc), 32'd4);
    chk_b("drop_ready_high", m_ready, 1'b1);
    chk_v("drop_pending3", 32'(m_fp), 32'd3);
    chk_v("drop_wcount", 32'(m_wc), 32'd0);
    drain(NB * D);
    chk_v("drop_pending_end", 32'(m_fp), 32'd0);

    // ---------------- commit and release on the same edge ----------------
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < D; i++) wr(16'(300 + i), 1'b1);
    for (int i = 0; i < D - 1; i++) wr(16'(308 + i), 1'b1);
    chk_v("sim_wcount7", 32'(m_wc), 32'd7);
    chk_v("sim_pending1_pre", 32'(m_fp), 32'd1);
    rr = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (k == D - 1) begin
        wv = 1'b1;
        wd = 16'd315;
        exp_q.push_back(16'd315);
        chk_b("sim_ready", m_ready, 1'b1);
      end
      expect_pop("sim");
      step();
    end
    wv = 1'b0;
    chk_v("sim_pending1_post", 32'(m_fp), 32'd1);
    chk_b("sim_frame_ready", m_fr, 1'b1);
    chk_v("sim_state_fetch", 32'(m_st), 32'd1);
    drain(D);
    chk_v("sim_pending_end", 32'(m_fp), 32'd0);

    // ---------------- reader stall, read_ready toggling ----------------
    do_reset();
    for (int i = 0; i < 2 * D; i++) wr(16'(400 + i), 1'b1);
    got = 0;
    stall_prev = 1'b0;
    prev = '0;
    for (int c = 0; c < 80 && got < 2 * D; c++) begin
      rr = (c % 2) == 0;
      if (m_valid && stall_prev) chk_v("stall_stable", 32'(m_data), 32'(prev));
      if (m_valid && rr) begin
        expect_pop("toggle");
        got++;
      end
      stall_prev = m_valid && !rr;
      prev = m_data;
      step();
    end
    rr = 1'b0;
    chk_v("toggle_count", 32'(got), 32'd16);
    chk_v("toggle_pending_end", 32'(m_fp), 32'd0);
    chk_b("toggle_valid_end", m_valid, 1'b0);

    // ---------------- reset mid-frame ----------------
    do_reset();
    for (int i = 0; i < D; i++) wr(16'(500 + i), 1'b1);
    for (int i = 0; i < 5; i++) wr(16'(508 + i), 1'b1);
    chk_b("mid_valid_pre", m_valid, 1'b1);
    chk_v("mid_wcount_pre", 32'(m_wc), 32'd5);
    chk_v("mid_pending_pre", 32'(m_fp), 32'd1);
    rst = 1'b1;
    #1;
    chk_b("mid_rst_valid", m_valid, 1'b0);
    chk_v("mid_rst_pending", 32'(m_fp), 32'd0);
    chk_v("mid_rst_wcount", 32'(m_wc), 32'd0);
    chk_b("mid_rst_ready", m_ready, 1'b1);
    chk_b("mid_rst_last", m_last, 1'b0);
    chk_v("mid_rst_state", 32'(m_st), 32'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    rd_pos = 0;
    repeat (3) step();
    chk_b("mid_no_valid", m_valid, 1'b0);
    for (int i = 0; i < D; i++) wr(16'(600 + i), 1'b1);
    drain(D);
    chk_v("mid_pending_end", 32'(m_fp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_buffer_mc.md
PINGPONG_BUFFER_MC -- requirements
Module: pingpong_buffer_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 36, sample width in bits (1..72).
REQ-002 SHALL have parameter DEPTH, default 256, samples per frame (power of two, >=4).
REQ-003 SHALL have parameter NUM_BANKS, default 2, frame banks in the ring (2..8).
REQ-004 SHALL have parameter DROP_MODE, default 0: 0 = backpressure writer when full, 1 = accept and discard when full.
REQ-005 SHALL have localparams ADDR_WIDTH = $clog2(DEPTH) and BANK_WIDTH = $clog2(NUM_BANKS), the latter with a minimum of 1.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port write_data_i, input, WIDTH, signed sample.
REQ-009 SHALL have ports write_valid_i (input, 1) and write_ready_o (output, 1), the write handshake.
REQ-010 SHALL have port read_data_o, output, WIDTH, signed sample.
REQ-011 SHALL have ports read_valid_o (output, 1) and read_ready_i (input, 1), the read handshake.
REQ-012 SHALL have port read_last_o, output, 1, high with the final sample of each frame.
REQ-013 SHALL have port frame_ready_o, output, 1, one-cycle pulse per committed frame.
REQ-014 SHALL have port overflow_o, output, 1, one-cycle pulse per discarded sample.
REQ-015 SHALL have port frames_pending_o, output, BANK_WIDTH+1, count of committed, unread banks.
REQ-016 SHALL have port write_count_o, output, ADDR_WIDTH+1, samples in the current write bank.
REQ-017 SHALL have port drop_count_o, output, 16, discarded-sample count, saturating at 0xFFFF.

Function
REQ-018 SHALL store data in an inferred array of NUM_BANKS*DEPTH words with a 1-cycle synchronous read and no vendor primitive.
REQ-019 SHALL accept a write when write_valid_i && write_ready_o, storing the sample at {wr_bank, wr_addr} and incrementing wr_addr.
REQ-020 SHALL commit the bank on acceptance of sample DEPTH-1: frame_ready_o pulses next cycle, frames_pending increments, wr_bank advances modulo NUM_BANKS, and wr_addr and write_count clear.
REQ-021 SHALL treat the ring as full when frames_pending == NUM_BANKS.
REQ-022 SHALL drive write_ready_o = !full when DROP_MODE=0.
REQ-023 SHALL hold write_ready_o = 1 when DROP_MODE=1; accepted samples while full are not stored, overflow_o pulses, and drop_count_o increments.
REQ-024 SHALL use reader FSM states R_IDLE, R_FETCH, R_STREAM.
REQ-025 SHALL move R_IDLE -> R_FETCH when frames_pending > 0, issuing the read of {rd_bank, 0}.
REQ-026 SHALL move R_FETCH -> R_STREAM with read_valid_o asserted.
REQ-027 SHALL hold read_valid_o in R_STREAM and advance on read_valid_o && read_ready_i, with a 2-entry skid so sustained throughput is 1 sample/cycle and read_data_o is stable while read_valid_o && !read_ready_i.
REQ-028 SHALL, on the handshake of the sample flagged read_last_o, release the bank: frames_pending decrements, rd_bank advances modulo NUM_BANKS, and the FSM goes to R_FETCH if frames_pending (post-update) > 0, else R_IDLE.
REQ-029 SHALL achieve a latency of 2 cycles from the commit edge to read_valid_o when the reader is in R_IDLE.
REQ-030 SHALL leave frames_pending unchanged when a commit and a release occur in the same cycle, and SHALL NOT stall either side.
REQ-031 SHALL make a freshly released bank writable in the cycle after release (write_ready_o rises then when DROP_MODE=0).
REQ-032 SHALL NOT pass read data combinationally from write_data_i; read_data_o is always sourced from a register.

Reset
REQ-033 SHALL, on rst_i high, asynchronously clear wr_bank, wr_addr, rd_bank, frames_pending, write_count_o, drop_count_o, read_valid_o, read_last_o, frame_ready_o, and overflow_o, and set the FSM to R_IDLE.
REQ-034 SHALL drive write_ready_o = 1 during and after reset.
REQ-035 SHALL discard any partial or committed frames when reset is asserted mid-operation, and SHALL NOT assert read_valid_o until a new frame commits.
REQ-036 SHALL NOT reset memory contents.

Verification (WIDTH=16, DEPTH=8, NUM_BANKS=3)
REQ-037 SHALL cover single frame: write 0..7 back-to-back with read_ready_i=1 -> frame_ready_o pulse, read_valid_o 2 cycles after commit, read 0..7 on consecutive cycles, read_last_o on 7.
REQ-038 SHALL cover backpressure: DROP_MODE=0, write 24 samples with read_ready_i=0 -> frames_pending=3, write_ready_o=0; one frame read -> write_ready_o=1 the following cycle.
REQ-039 SHALL cover drop mode: DROP_MODE=1, write 28 samples with read_ready_i=0 -> 4 overflow_o pulses, drop_count_o=4, stored frames intact.
REQ-040 SHALL cover simultaneous commit and release: frames_pending=1, final write coincides with last read handshake -> frames_pending stays 1 and data order is preserved.
REQ-041 SHALL cover reader stall: toggle read_ready_i every cycle -> no lost or duplicated samples and read_data_o stable while stalled.
REQ-042 SHALL cover reset mid-frame: assert rst_i after 5 writes -> outputs at reset values, and the next full frame reads back correctly.
